// File: rtl/soc_system_pio_ext_if.sv
// soc_system_pio_ext_if: Avalon-MM slave bus bundle for the extended PIO.
interface soc_system_pio_ext_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   modport master (output address, chipselect, write_n, writedata, input readdata);
   modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/soc_system_pio_ext.sv
// soc_system_pio_ext: Avalon-MM PIO with set/clear output, synchronised input,
// edge capture (W1C) and a maskable level interrupt.
module soc_system_pio_ext #(
   parameter int              WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter int              EDGE_TYPE   = 0,
   parameter int              SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   soc_system_pio_ext_if.slave  bus,
   input  logic [WIDTH-1:0]     in_port,
   output logic [WIDTH-1:0]     out_port,
   output logic                 irq
);
   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0] prev_q, data_out_q, data_out_d, mask_q, mask_d, cap_q, cap_d;
   logic [WIDTH-1:0] sync, det, wd, rsel;
   logic [31:0]      readdata_q, readdata_d, rd_ext;
   logic             wr, rd;

   assign sync = sync_q[SYNC_STAGES-1];
   assign wd   = bus.writedata[WIDTH-1:0];
   assign wr   = bus.chipselect & ~bus.write_n;
   assign rd   = bus.chipselect & bus.write_n;
   assign det  = EDGE_TYPE == 0 ? sync & ~prev_q :
                 EDGE_TYPE == 1 ? ~sync & prev_q : sync ^ prev_q;

   // a fresh edge is ORed in after the W1C so a same-cycle set wins
   always_comb begin
      data_out_d = !wr ? data_out_q :
                   bus.address == 3'd0 ? wd :
                   bus.address == 3'd4 ? data_out_q | wd :
                   bus.address == 3'd5 ? data_out_q & ~wd : data_out_q;
      mask_d     = wr && bus.address == 3'd2 ? wd : mask_q;
      cap_d      = (wr && bus.address == 3'd3 ? cap_q & ~wd : cap_q) | det;
      rsel       = bus.address == 3'd0 ? data_out_q :
                   bus.address == 3'd1 ? sync :
                   bus.address == 3'd2 ? mask_q :
                   bus.address == 3'd3 ? cap_q : '0;
      rd_ext            = '0;
      rd_ext[WIDTH-1:0] = rsel;
      readdata_d = rd ? rd_ext : readdata_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q     <= '0;
         prev_q     <= '0;
         data_out_q <= RESET_VALUE;
         mask_q     <= '0;
         cap_q      <= '0;
         readdata_q <= '0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], in_port};
         prev_q     <= sync;
         data_out_q <= data_out_d;
         mask_q     <= mask_d;
         cap_q      <= cap_d;
         readdata_q <= readdata_d;
      end
   end

   assign out_port     = data_out_q;
   assign bus.readdata = readdata_q;
   assign irq          = |(cap_q & mask_q);
endmodule

// File: tb/tb_soc_system_pio_ext.sv
// tb_soc_system_pio_ext: three PIO variants (rise/S2, fall/S3, any/S2) driven in
// lockstep and checked against an input-history reference model.
module tb_soc_system_pio_ext;
   localparam int ET[3] = '{0, 1, 2};
   localparam int ST[3] = '{2, 3, 2};

   logic clk = 1'b0, reset_n = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]  addr = '0;
   logic        cs = 1'b0, wn = 1'b1;
   logic [31:0] wdata = '0;
   logic [7:0]  pin = '0;
   logic [7:0]  pout [3];
   logic        irq [3];
   logic [31:0] rd [3];

   for (genvar g = 0; g < 3; g++) begin : gd
      soc_system_pio_ext_if b ();
      assign b.address    = addr;
      assign b.chipselect = cs;
      assign b.write_n    = wn;
      assign b.writedata  = wdata;
      assign rd[g]        = b.readdata;
      soc_system_pio_ext #(.WIDTH(8), .RESET_VALUE(8'hA5), .EDGE_TYPE(ET[g]), .SYNC_STAGES(ST[g])) dut (
         .clk(clk), .reset_n(reset_n), .bus(b.slave),
         .in_port(pin), .out_port(pout[g]), .irq(irq[g]));
   end

   int tests = 0, fails = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // model: registers plus a history of sampled pins (h[0] = newest sample)
   logic [7:0]  m_out [3], m_mask [3], m_cap [3];
   logic [31:0] m_rd [3];
   logic [7:0]  h [8];

   task automatic m_reset;
      for (int d = 0; d < 3; d++) begin
         m_out[d] = 8'hA5; m_mask[d] = '0; m_cap[d] = '0; m_rd[d] = '0;
      end
      for (int k = 0; k < 8; k++) h[k] = '0;
   endtask

   function automatic logic [7:0] edges(input int et, input logic [7:0] nw, input logic [7:0] od);
      if (et == 0) return nw & ~od;
      if (et == 1) return ~nw & od;
      return nw ^ od;
   endfunction

   task automatic m_step;
      logic [7:0] wd, e, s;
      if (!reset_n) begin m_reset(); return; end
      wd = wdata[7:0];
      for (int d = 0; d < 3; d++) begin
         s = h[ST[d]-1];
         e = edges(ET[d], s, h[ST[d]]);
         if (cs && wn)
            m_rd[d] = {24'h0, addr == 0 ? m_out[d] : addr == 1 ? s :
                              addr == 2 ? m_mask[d] : addr == 3 ? m_cap[d] : 8'h00};
         if (cs && !wn)
            case (addr)
               3'd0: m_out[d] = wd;
               3'd2: m_mask[d] = wd;
               3'd3: m_cap[d] = m_cap[d] & ~wd;
               3'd4: m_out[d] = m_out[d] | wd;
               3'd5: m_out[d] = m_out[d] & ~wd;
               default: ;
            endcase
         m_cap[d] = m_cap[d] | e;
      end
      for (int k = 7; k > 0; k--) h[k] = h[k-1];
      h[0] = pin;
   endtask

   task automatic check_all;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("out%0d", d), {24'h0, pout[d]}, {24'h0, m_out[d]});
         chk($sformatf("irq%0d", d), {31'h0, irq[d]}, {31'h0, |(m_cap[d] & m_mask[d])});
         chk($sformatf("rd%0d", d), rd[d], m_rd[d]);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      m_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic bus(input logic w, input logic [2:0] a, input logic [31:0] d);
      cs = 1'b1; wn = ~w; addr = a; wdata = d;
      tick();
      cs = 1'b0; wn = 1'b1;
   endtask

   task automatic async_reset;
      reset_n = 1'b0;
      #1;
      m_reset();
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("arst_out%0d", d), {24'h0, pout[d]}, 32'hA5);
         chk($sformatf("arst_irq%0d", d), {31'h0, irq[d]}, 32'h0);
         chk($sformatf("arst_rd%0d", d), rd[d], 32'h0);
      end
      tick();
      reset_n = 1'b1;
   endtask

   initial begin
      m_reset();
      tick(); tick();
      chk("rst_out", {24'h0, pout[0]}, 32'hA5);
      chk("rst_irq", {31'h0, irq[0]}, 32'h0);
      reset_n = 1'b1;
      tick();
      bus(1'b0, 3'd2, 0);
      chk("rd_mask0", rd[0], 32'h0);
      bus(1'b1, 3'd0, 32'h1234_56F0);
      chk("wr_out", {24'h0, pout[0]}, 32'hF0);
      bus(1'b1, 3'd4, 32'h0F);
      chk("outset", {24'h0, pout[0]}, 32'hFF);
      bus(1'b1, 3'd5, 32'h81);
      chk("outclr", {24'h0, pout[0]}, 32'h7E);
      bus(1'b0, 3'd0, 0);
      chk("rd_out", rd[0], 32'h7E);
      // rising edge on bit3 lands exactly three edges after first sample
      bus(1'b1, 3'd2, 32'h08);
      pin = 8'h08;
      tick(); tick();
      chk("irq_early", {31'h0, irq[0]}, 32'h0);
      tick();
      chk("irq_edge", {31'h0, irq[0]}, 32'h1);
      bus(1'b0, 3'd1, 0);
      chk("rd_din", rd[0], 32'h08);
      bus(1'b0, 3'd3, 0);
      chk("rd_cap", rd[0], 32'h08);
      // W1C in the same cycle as a new edge: set wins
      pin = 8'h00;
      tick(); tick(); tick();
      pin = 8'h08;
      tick(); tick();
      bus(1'b1, 3'd3, 32'h08);
      chk("w1c_race_irq", {31'h0, irq[0]}, 32'h1);
      bus(1'b1, 3'd3, 32'h08);
      chk("w1c_irq", {31'h0, irq[0]}, 32'h0);
      // any-edge variant: bit0 falls and bit7 rises together
      pin = 8'h09;
      repeat (4) tick();
      bus(1'b1, 3'd3, 32'hFF);
      pin = 8'h88;
      tick(); tick(); tick();
      bus(1'b0, 3'd3, 0);
      chk("any_cap", rd[2], 32'h81);
      bus(1'b1, 3'd2, 32'h01);
      chk("any_irq", {31'h0, irq[2]}, 32'h1);
      bus(1'b1, 3'd3, 32'h01);
      chk("any_irq_clr", {31'h0, irq[2]}, 32'h0);
      bus(1'b0, 3'd3, 0);
      chk("any_cap_left", rd[2], 32'h80);
      // reserved and write-only addresses
      bus(1'b1, 3'd6, 32'hFFFF_FFFF);
      bus(1'b1, 3'd7, 32'hFFFF_FFFF);
      for (int a = 4; a < 8; a++) begin
         bus(1'b0, 3'(a), 0);
         chk($sformatf("rd_res%0d", a), rd[0], 32'h0);
      end
      chk("res_out", {24'h0, pout[0]}, 32'h7E);
      async_reset();
      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         cs = $urandom_range(0, 3) != 0;
         wn = $urandom_range(0, 1);
         addr = 3'($urandom_range(0, 7));
         wdata = $urandom;
         if ($urandom_range(0, 3) == 0) pin = 8'($urandom);
         if ($urandom_range(0, 99) == 0) async_reset();
         else tick();
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
